// File: rtl/band_envelope_detector_pkg.sv
// Shared fixed-point package for the band filter chain.
// Holds the common sample width and small arithmetic helpers used by the
// filter cascade and by the per-band envelope detectors:
//   sign_extend : widen a sample to a full-precision product width
//   round_frac  : round a full-precision product back to a sample
//   sat_abs     : magnitude of a sample, saturating the most negative code
package band_envelope_detector_pkg;

  localparam int WORD_SIZE = 18;
  localparam int FRAC_BITS = WORD_SIZE - 2;

  function automatic logic signed [2*WORD_SIZE-1:0] sign_extend(
    input logic signed [WORD_SIZE-1:0] x
  );
    return {{WORD_SIZE{x[WORD_SIZE-1]}}, x};
  endfunction

  // Round-half-up on the fractional bits, then drop them.
  function automatic logic signed [WORD_SIZE-1:0] round_frac(
    input logic signed [2*WORD_SIZE-1:0] p
  );
    logic signed [2*WORD_SIZE-1:0] half_lsb;
    logic signed [2*WORD_SIZE-1:0] sum;
    half_lsb = (2*WORD_SIZE)'(1) << (FRAC_BITS - 1);
    sum      = p + half_lsb;
    return sum[FRAC_BITS+WORD_SIZE-1:FRAC_BITS];
  endfunction

  // |x| as an unsigned WORD_SIZE-1 bit value. The most negative code has no
  // positive twin, so it maps to the largest positive magnitude.
  function automatic logic [WORD_SIZE-2:0] sat_abs(
    input logic signed [WORD_SIZE-1:0] x
  );
    logic [WORD_SIZE-1:0] neg;
    if (x == {1'b1, {(WORD_SIZE-1){1'b0}}}) begin
      return '1;
    end
    if (x[WORD_SIZE-1]) begin
      neg = -x;
      return neg[WORD_SIZE-2:0];
    end
    return x[WORD_SIZE-2:0];
  endfunction

endpackage

// File: rtl/band_envelope_detector_level_output_slot.sv
// level_output_slot: one-entry hold register between a producer that emits a
// single-cycle result strobe and a valid/ready consumer.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   strobe     new_level is offered this cycle (producer cannot stall)
//   new_level  level offered with strobe
//   level      held level, stable while valid && !ready
//   valid      level holds an unconsumed value
//   ready      consumer takes level when valid && ready
//   overrun    sticky: a strobed level was dropped because the slot was full
// Handshake: a transfer happens on every rising edge where valid && ready.
// The slot accepts a strobe when empty or when it is emptied on the same edge;
// otherwise the new value is discarded and overrun is set until reset.
module level_output_slot #(
  parameter int LEVEL_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  strobe,
  input  logic [LEVEL_BITS-1:0] new_level,
  output logic [LEVEL_BITS-1:0] level,
  output logic                  valid,
  input  logic                  ready,
  output logic                  overrun
);

  always_ff @(posedge clk) begin
    if (rst) begin
      level   <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else if (strobe) begin
      if (!valid || ready) begin
        level <= new_level;
        valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/band_envelope_detector.sv
// band_envelope_detector: turns one band-pass filter's signed sample stream
// into a display level for one visualizer bar.
// Pipeline: stage 1 rectifies the accepted sample; stage 2 tracks the window
// peak and, on the last sample of a window, updates an instant-attack /
// exponential-decay envelope and strobes its top bits into the output slot.
// Ports:
//   inClock   sole clock
//   rst       synchronous active-high reset (discards any partial window)
//   inData    signed band sample, accepted when inValid is high
//   inValid   sample qualifier
//   outLevel  unsigned bar level, one per window
//   outValid  outLevel holds a valid value
//   outReady  consumer takes outLevel when outValid && outReady
//   overrun   sticky: a window result was dropped under backpressure
module band_envelope_detector
  import band_envelope_detector_pkg::*;
#(
  parameter int WINDOW_LOG2 = 10,
  parameter int DECAY_SHIFT = 4,
  parameter int LEVEL_BITS  = 8
) (
  input  logic                        inClock,
  input  logic                        rst,
  input  logic signed [WORD_SIZE-1:0] inData,
  input  logic                        inValid,
  output logic [LEVEL_BITS-1:0]       outLevel,
  output logic                        outValid,
  input  logic                        outReady,
  output logic                        overrun
);

  localparam int ENV_BITS = WORD_SIZE - 1;
  // A one-sample window still needs a one-bit counter that simply stays 0.
  localparam int CNT_BITS = (WINDOW_LOG2 > 0) ? WINDOW_LOG2 : 1;
  localparam logic [CNT_BITS-1:0] LAST_COUNT = CNT_BITS'((1 << WINDOW_LOG2) - 1);

  logic [CNT_BITS-1:0]   count;
  logic                  is_last;
  logic [ENV_BITS-1:0]   s1_mag;
  logic                  s1_valid;
  logic                  s1_last;
  logic [ENV_BITS-1:0]   window_peak;
  logic [ENV_BITS-1:0]   env;

  logic [ENV_BITS-1:0]   peak_next;
  logic [ENV_BITS-1:0]   decay_step;
  logic [ENV_BITS-1:0]   env_next;
  logic                  strobe;
  logic [LEVEL_BITS-1:0] new_level;

  assign is_last = (count == LAST_COUNT);

  always_comb begin
    peak_next  = (s1_mag > window_peak) ? s1_mag : window_peak;
    decay_step = env >> DECAY_SHIFT;
    // A minimum step of 1 lets the envelope reach exactly 0; the step never
    // exceeds env because env > peak_next >= 0 on the decay path.
    if (decay_step == '0) begin
      decay_step = ENV_BITS'(1);
    end
    env_next  = (peak_next >= env) ? peak_next : (env - decay_step);
    strobe    = s1_valid && s1_last;
    new_level = env_next[ENV_BITS-1 -: LEVEL_BITS];
  end

  always_ff @(posedge inClock) begin
    if (rst) begin
      count       <= '0;
      s1_mag      <= '0;
      s1_valid    <= 1'b0;
      s1_last     <= 1'b0;
      window_peak <= '0;
      env         <= '0;
    end else begin
      s1_valid <= inValid;
      if (inValid) begin
        s1_mag  <= sat_abs(inData);
        s1_last <= is_last;
        count   <= is_last ? '0 : count + CNT_BITS'(1);
      end
      if (s1_valid) begin
        if (s1_last) begin
          window_peak <= '0;
          env         <= env_next;
        end else begin
          window_peak <= peak_next;
        end
      end
    end
  end

  level_output_slot #(
    .LEVEL_BITS(LEVEL_BITS)
  ) u_slot (
    .clk       (inClock),
    .rst       (rst),
    .strobe    (strobe),
    .new_level (new_level),
    .level     (outLevel),
    .valid     (outValid),
    .ready     (outReady),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_band_envelope_detector.sv
module tb_band_envelope_detector;

  localparam int WS  = 18;
  localparam int WL  = 2;
  localparam int DS  = 2;
  localparam int LB  = 8;
  localparam int WIN = 1 << WL;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic signed [WS-1:0] in_data;
  logic                 in_valid;
  logic                 out_ready;
  logic [LB-1:0]        out_level;
  logic                 out_valid;
  logic                 overrun;

  band_envelope_detector #(
    .WINDOW_LOG2(WL),
    .DECAY_SHIFT(DS),
    .LEVEL_BITS (LB)
  ) dut (
    .inClock (clk),
    .rst     (rst),
    .inData  (in_data),
    .inValid (in_valid),
    .outLevel(out_level),
    .outValid(out_valid),
    .outReady(out_ready),
    .overrun (overrun)
  );

  // reference model state
  int            m_env;
  int            win_q[$];
  logic [LB-1:0] exp_q[$];
  logic          m_valid;
  logic          m_over;
  logic [LB-1:0] m_level;

  int checks   = 0;
  int failures = 0;
  int n_pulses = 0;

  function automatic int mag_of(input logic signed [WS-1:0] d);
    int v;
    v = int'(d);
    if (v == -(1 << (WS-1))) return (1 << (WS-1)) - 1;
    return (v < 0) ? -v : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, act, exp);
    end
  endtask

  // One rising edge of behaviour, described window by window.
  task automatic model_edge(input logic signed [WS-1:0] d, input logic v,
                            input logic r, input logic rs);
    int pk;
    int step;
    logic [LB-1:0] lvl;
    if (rs) begin
      m_env = 0;
      win_q.delete();
      exp_q.delete();
      m_valid = 1'b0;
      m_level = '0;
      m_over  = 1'b0;
      return;
    end
    if (exp_q.size() > 0) begin
      lvl = exp_q.pop_front();
      if (!m_valid || r) begin
        m_level = lvl;
        m_valid = 1'b1;
      end else begin
        m_over = 1'b1;
      end
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
    if (v) begin
      win_q.push_back(mag_of(d));
      if (win_q.size() == WIN) begin
        pk = 0;
        foreach (win_q[i]) if (win_q[i] > pk) pk = win_q[i];
        if (pk >= m_env) begin
          m_env = pk;
        end else begin
          step  = m_env / (1 << DS);
          if (step < 1) step = 1;
          m_env = m_env - step;
        end
        win_q.delete();
        // result becomes visible one edge later (two cycles after the sample)
        exp_q.push_back(LB'(m_env / (1 << (WS-1-LB))));
      end
    end
  endtask

  // driver: apply inputs for one cycle, then check all outputs after the edge
  task automatic cyc(input logic signed [WS-1:0] d, input logic v,
                     input logic r, input logic rs);
    rst       = rs;
    in_data   = d;
    in_valid  = v;
    out_ready = r;
    @(posedge clk);
    #1;
    model_edge(d, v, r, rs);
    chk("out_valid", out_valid, m_valid);
    chk("out_level", out_level, m_level);
    chk("overrun",   overrun,   m_over);
    if (out_valid) n_pulses++;
  endtask

  task automatic win4(input int a, input int b, input int c, input int d, input logic r);
    cyc(WS'(a), 1'b1, r, 1'b0);
    cyc(WS'(b), 1'b1, r, 1'b0);
    cyc(WS'(c), 1'b1, r, 1'b0);
    cyc(WS'(d), 1'b1, r, 1'b0);
  endtask

  task automatic idle(input logic r);
    cyc(WS'($urandom), 1'b0, r, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;

    // 1. reset with random activity
    for (int i = 0; i < 3; i++) cyc(WS'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    chk("t1_valid", out_valid, 0);
    chk("t1_level", out_level, 0);
    chk("t1_overrun", overrun, 0);

    // 2. constant window, output two cycles after the 4th sample, single pulse
    win4(65536, 65536, 65536, 65536, 1'b1);
    idle(1'b1);
    chk("t2_valid", out_valid, 1);
    chk("t2_level", out_level, 128);
    idle(1'b1);
    chk("t2_pulse_end", out_valid, 0);

    // 3. most negative sample saturates
    win4(100, -131072, 5, 0, 1'b1);
    idle(1'b1);
    chk("t3_level", out_level, 255);

    // 4. decay from 65536 through zero windows
    cyc('0, 1'b0, 1'b1, 1'b1);
    win4(65536, 65536, 65536, 65536, 1'b1);
    idle(1'b1);
    chk("t4_start", out_level, 128);
    win4(0, 0, 0, 0, 1'b1); idle(1'b1); chk("t4_decay1", out_level, 96);
    win4(0, 0, 0, 0, 1'b1); idle(1'b1); chk("t4_decay2", out_level, 72);
    win4(0, 0, 0, 0, 1'b1); idle(1'b1); chk("t4_decay3", out_level, 54);
    for (int i = 0; i < 45; i++) win4(0, 0, 0, 0, 1'b1);
    idle(1'b1);
    chk("t4_env_zero", m_env, 0);
    chk("t4_zero_level", out_level, 0);
    win4(0, 0, 0, 0, 1'b1); idle(1'b1);
    chk("t4_zero_hold", out_level, 0);

    // 5. backpressure across two windows
    cyc('0, 1'b0, 1'b0, 1'b1);
    win4(65536, 65536, 65536, 65536, 1'b0);
    idle(1'b0);
    chk("t5_held_valid", out_valid, 1);
    chk("t5_no_overrun", overrun, 0);
    win4(131071, 131071, 131071, 131071, 1'b0);
    idle(1'b0);
    chk("t5_overrun", overrun, 1);
    chk("t5_level_kept", out_level, 128);
    idle(1'b1);
    chk("t5_drained", out_valid, 0);
    win4(0, 0, 0, 0, 1'b1);
    idle(1'b1);
    chk("t5_decay_from_max", out_level, 192);
    chk("t5_overrun_sticky", overrun, 1);

    // 6. gapped inValid, and reset discarding a partial window
    cyc('0, 1'b0, 1'b1, 1'b1);
    n_pulses = 0;
    for (int i = 0; i < 8; i++) cyc(WS'(65536), 1'(i % 2 == 0), 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    chk("t6_gapped_pulses", n_pulses, 1);
    n_pulses = 0;
    cyc(WS'(65536), 1'b1, 1'b1, 1'b0);
    cyc(WS'(65536), 1'b1, 1'b1, 1'b0);
    cyc('0, 1'b0, 1'b1, 1'b1);
    win4(32768, 32768, 32768, 32768, 1'b1);
    idle(1'b1);
    chk("t6_after_reset_level", out_level, 64);
    idle(1'b1);
    idle(1'b1);
    chk("t6_after_reset_pulses", n_pulses, 1);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic signed [WS-1:0] d;
      d = ($urandom_range(0, 15) == 0) ? WS'(-131072) : WS'($urandom);
      cyc(d, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 99) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
